// File: rtl/wptr_full_lvl_if.sv
// Write-side bundle for wptr_full_lvl: client request/threshold in, pointer and status out.
// wovf_clr exists only when WPTR_FULL_OVF_EN is defined.
interface wptr_full_lvl_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   af_thresh;
`ifdef WPTR_FULL_OVF_EN
    logic                wovf_clr;
`endif
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

`ifdef WPTR_FULL_OVF_EN
    modport master (output winc, wq2_rptr, af_thresh, wovf_clr,
                    input  waddr, wptr, wfull, walmost_full, wlevel, wovf);
    modport slave  (input  winc, wq2_rptr, af_thresh, wovf_clr,
                    output waddr, wptr, wfull, walmost_full, wlevel, wovf);
`else
    modport master (output winc, wq2_rptr, af_thresh,
                    input  waddr, wptr, wfull, walmost_full, wlevel, wovf);
    modport slave  (input  winc, wq2_rptr, af_thresh,
                    output waddr, wptr, wfull, walmost_full, wlevel, wovf);
`endif
endinterface

// File: rtl/wptr_full_lvl.sv
// Async FIFO write-side pointer, full/almost-full flags and fill level.
// Define WPTR_FULL_OVF_EN to build the sticky overflow flag with its clear input.
module wptr_full_lvl #(
    parameter int ADDRSIZE = 4
) (
    input  logic          wclk,
    input  logic          wrst_n,
    wptr_full_lvl_if.slave wif
);
    localparam int AW = ADDRSIZE;

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] wlevel_q, wlevel_d;
    logic [AW:0] rbin;
    logic        wfull_q, wfull_d;
    logic        waf_q, waf_d;
    logic        wacc;

    assign wacc   = wif.winc & ~wfull_q;
    assign wbin_d = wbin_q + {{AW{1'b0}}, wacc};
    assign wptr_d = (wbin_d >> 1) ^ wbin_d;

    // Gray to binary: each bit is the XOR of itself and every bit above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(wif.wq2_rptr >> i);
        end
    end

    // Level is computed against the lagging read pointer, so it never under-reports.
    assign wlevel_d = wbin_d - rbin;
    assign wfull_d  = (wptr_d == {~wif.wq2_rptr[AW:AW-1], wif.wq2_rptr[AW-2:0]});
    assign waf_d    = (wlevel_d >= wif.af_thresh);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            waf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            waf_q    <= waf_d;
        end
    end

`ifdef WPTR_FULL_OVF_EN
    logic wovf_q, wovf_d;

    // A dropped write in the same cycle as a clear keeps the flag set.
    assign wovf_d = (wif.winc & wfull_q) | (wovf_q & ~wif.wovf_clr);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) wovf_q <= 1'b0;
        else         wovf_q <= wovf_d;
    end

    assign wif.wovf = wovf_q;
`else
    assign wif.wovf = 1'b0;
`endif

    assign wif.waddr        = wbin_q[AW-1:0];
    assign wif.wptr         = wptr_q;
    assign wif.wfull        = wfull_q;
    assign wif.walmost_full = waf_q;
    assign wif.wlevel       = wlevel_q;
endmodule

// File: tb/tb_wptr_full_lvl.sv
// Directed bench for wptr_full_lvl (ADDRSIZE=4): fill, overflow, drain, wrap, thresholds, reset.
module tb_wptr_full_lvl;
    logic wclk;
    logic wrst_n;
    int   checks = 0;
    int   errors = 0;

    wptr_full_lvl_if #(.ADDRSIZE(4)) wif ();

    wptr_full_lvl #(.ADDRSIZE(4)) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .wif   (wif)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wif.winc = 1'b0;
        wif.wq2_rptr = '0;
`ifdef WPTR_FULL_OVF_EN
        wif.wovf_clr = 1'b0;
`endif
        wrst_n = 1'b0;
        #1;
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wif.af_thresh = 5'd12;
        wif.winc = 1'b0;
        wif.wq2_rptr = '0;
`ifdef WPTR_FULL_OVF_EN
        wif.wovf_clr = 1'b0;
`endif
        wrst_n = 1'b0;
        #2;
        checks++;
        if ({wif.waddr, wif.wptr, wif.wfull, wif.walmost_full, wif.wlevel, wif.wovf} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {wif.waddr, wif.wptr, wif.wfull, wif.walmost_full, wif.wlevel, wif.wovf});
        end
        #1;
        wrst_n = 1'b1;
        step();
        checks++;
        if (wif.walmost_full !== 1'b0 || wif.wlevel !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle: af=%b lvl=%0d want af=0 lvl=0", wif.walmost_full, wif.wlevel);
        end
    endtask

    task automatic test_fill();
        logic [4:0] kk;
        wif.af_thresh = 5'd12;
        wif.wq2_rptr = '0;
        checks++;
        if (wif.waddr !== 4'd0) begin
            errors++;
            $display("FAIL fill_start_addr: got %0d want 0", wif.waddr);
        end
        wif.winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            kk = k[4:0];
            step();
            checks++;
            if (wif.waddr !== kk[3:0] || wif.wlevel !== kk) begin
                errors++;
                $display("FAIL fill_addr_lvl k=%0d: got addr=%0d lvl=%0d want addr=%0d lvl=%0d",
                         k, wif.waddr, wif.wlevel, kk[3:0], kk);
            end
            checks++;
            if (wif.walmost_full !== (k >= 12) || wif.wfull !== (k == 16)) begin
                errors++;
                $display("FAIL fill_flags k=%0d: got af=%b full=%b want af=%b full=%b",
                         k, wif.walmost_full, wif.wfull, k >= 12, k == 16);
            end
        end
        checks++;
        if (wif.wptr !== 5'b11000) begin
            errors++;
            $display("FAIL fill_wptr: got %b want 11000", wif.wptr);
        end
    endtask

    task automatic test_overflow();
        wif.winc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (wif.waddr !== 4'd0 || wif.wptr !== 5'b11000 || wif.wfull !== 1'b1 || wif.wlevel !== 5'd16) begin
                errors++;
                $display("FAIL ovf_hold k=%0d: got addr=%0d wptr=%b full=%b lvl=%0d want 0/11000/1/16",
                         k, wif.waddr, wif.wptr, wif.wfull, wif.wlevel);
            end
            checks++;
`ifdef WPTR_FULL_OVF_EN
            if (wif.wovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_set k=%0d: got %b want 1", k, wif.wovf);
            end
`else
            if (wif.wovf !== 1'b0) begin
                errors++;
                $display("FAIL ovf_tied k=%0d: got %b want 0", k, wif.wovf);
            end
`endif
        end
`ifdef WPTR_FULL_OVF_EN
        wif.winc = 1'b0;
        wif.wovf_clr = 1'b1;
        step();
        checks++;
        if (wif.wovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b want 0", wif.wovf);
        end
        wif.winc = 1'b1;
        step();
        checks++;
        if (wif.wovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b want 1", wif.wovf);
        end
        wif.wovf_clr = 1'b0;
`endif
        wif.winc = 1'b0;
    endtask

    task automatic test_drain();
        wif.wq2_rptr = 5'b00110;
        step();
        checks++;
        if (wif.wfull !== 1'b0 || wif.wlevel !== 5'd12 || wif.walmost_full !== 1'b1) begin
            errors++;
            $display("FAIL drain4: got full=%b lvl=%0d af=%b want 0/12/1",
                     wif.wfull, wif.wlevel, wif.walmost_full);
        end
        wif.wq2_rptr = 5'b00111;
        step();
        checks++;
        if (wif.wlevel !== 5'd11 || wif.walmost_full !== 1'b0) begin
            errors++;
            $display("FAIL drain5: got lvl=%0d af=%b want 11/0", wif.wlevel, wif.walmost_full);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] nb, rb, lv;
        do_reset();
        wif.af_thresh = 5'd17;
        wif.winc = 1'b1;
        for (int j = 0; j < 40; j++) begin
            nb = 5'(j + 1);
            rb = (j >= 2) ? 5'(j - 2) : 5'd0;
            lv = (j >= 2) ? 5'd3 : nb;
            wif.wq2_rptr = gray(rb);
            step();
            checks++;
            if (wif.wptr !== gray(nb) || wif.waddr !== nb[3:0] || wif.wlevel !== lv || wif.wfull !== 1'b0) begin
                errors++;
                $display("FAIL wrap j=%0d: got wptr=%b addr=%0d lvl=%0d full=%b want %b/%0d/%0d/0",
                         j, wif.wptr, wif.waddr, wif.wlevel, wif.wfull, gray(nb), nb[3:0], lv);
            end
            if (j == 30) begin
                checks++;
                if (wif.wptr !== 5'b10000 || wif.waddr !== 4'd15) begin
                    errors++;
                    $display("FAIL wrap_top: got wptr=%b addr=%0d want 10000/15", wif.wptr, wif.waddr);
                end
            end
            if (j == 31) begin
                checks++;
                if (wif.wptr !== 5'b00000 || wif.waddr !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_zero: got wptr=%b addr=%0d want 00000/0", wif.wptr, wif.waddr);
                end
            end
        end
        wif.winc = 1'b0;
    endtask

    task automatic test_thresholds();
        wif.af_thresh = 5'd0;
        do_reset();
        step();
        checks++;
        if (wif.walmost_full !== 1'b1 || wif.wlevel !== 5'd0) begin
            errors++;
            $display("FAIL thresh0: got af=%b lvl=%0d want 1/0", wif.walmost_full, wif.wlevel);
        end
        wif.af_thresh = 5'd17;
        do_reset();
        wif.winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (wif.walmost_full !== 1'b0) begin
                errors++;
                $display("FAIL thresh17 k=%0d: got af=%b want 0", k, wif.walmost_full);
            end
        end
        checks++;
        if (wif.wfull !== 1'b1) begin
            errors++;
            $display("FAIL thresh17_full: got %b want 1", wif.wfull);
        end
        wif.winc = 1'b0;
    endtask

    task automatic test_reset_mid();
        wif.af_thresh = 5'd12;
        do_reset();
        wif.winc = 1'b1;
        repeat (9) step();
        wif.winc = 1'b0;
        checks++;
        if (wif.wlevel !== 5'd9) begin
            errors++;
            $display("FAIL mid_pre: got lvl=%0d want 9", wif.wlevel);
        end
        #2;
        wrst_n = 1'b0;
        #1;
        checks++;
        if ({wif.waddr, wif.wptr, wif.wfull, wif.walmost_full, wif.wlevel, wif.wovf} !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h want 0",
                     {wif.waddr, wif.wptr, wif.wfull, wif.walmost_full, wif.wlevel, wif.wovf});
        end
        wrst_n = 1'b1;
        wif.winc = 1'b1;
        step();
        wif.winc = 1'b0;
        checks++;
        if (wif.waddr !== 4'd1 || wif.wlevel !== 5'd1 || wif.wptr !== 5'b00001) begin
            errors++;
            $display("FAIL mid_first_write: got addr=%0d lvl=%0d wptr=%b want 1/1/00001",
                     wif.waddr, wif.wlevel, wif.wptr);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_thresholds();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wptr_full_lvl.md
# wptr_full_lvl

Write-side pointer and status generator for the asynchronous FIFO, the next generation of the write-pointer/full-flag block. It keeps the binary write address and Gray write pointer, and derives a registered full flag from the read pointer already synchronised into the write domain. It adds a programmable almost-full flag, a registered fill-level count, and an optional sticky overflow error. It sits in the write clock domain between the write client, the dual-port RAM write address, and the read-to-write pointer synchroniser.

## Interface
- `ADDRSIZE`, default 4: RAM address width; depth = 2^ADDRSIZE; legal range ≥ 2.
- `wclk` input 1: write clock; all state updates on its rising edge.
- `wrst_n` input 1: asynchronous active-low reset.
- `winc` input 1: write request for this cycle.
- `wq2_rptr` input ADDRSIZE+1: Gray read pointer, already synchronised to `wclk`.
- `af_thresh` input ADDRSIZE+1: almost-full threshold in words; quasi-static.
- `wovf_clr` input 1: clears `wovf`; present only with the macro in the Configuration section.
- `waddr` output ADDRSIZE: binary RAM write address.
- `wptr` output ADDRSIZE+1: registered Gray write pointer, sent to the read-domain synchroniser.
- `wfull` output 1: FIFO full.
- `walmost_full` output 1: fill level ≥ `af_thresh`.
- `wlevel` output ADDRSIZE+1: registered fill level, 0..2^ADDRSIZE.
- `wovf` output 1: sticky overflow error.

## Operation
- Internal `wbin` is an ADDRSIZE+1 binary counter.
  - Next value: `wbinnext = wbin + (winc & ~wfull)`, modulo 2^(ADDRSIZE+1).
  - `wgraynext = (wbinnext >> 1) ^ wbinnext`.
  - `waddr = wbin[ADDRSIZE-1:0]`.
- Write acceptance:
  - A write is accepted when `winc & ~wfull`.
  - `winc` while `wfull` is dropped: the pointer does not move and the RAM enable is the client's responsibility.
- Read pointer conversion: `rbin` is the combinational Gray-to-binary conversion of `wq2_rptr` (XOR prefix from the MSB).
- Full detection:
  - `wfull_val` is true when `wgraynext` equals `wq2_rptr` with its two MSBs inverted and the remaining bits equal.
  - This is equivalent to `levelnext == 2^ADDRSIZE`.
- Level:
  - `levelnext = wbinnext - rbin`, modulo 2^(ADDRSIZE+1).
  - The level is an upper bound, because `wq2_rptr` lags the true read pointer. Full and almost-full are therefore pessimistic, never optimistic.
- Almost-full:
  - `walmost_full_val = (levelnext >= af_thresh)`, an unsigned compare.
  - `af_thresh = 0` gives the flag asserted from the first clock after reset.
  - `af_thresh > 2^ADDRSIZE` gives the flag never asserted.
- Wrap-around:
  - The pointer wraps from 2^(ADDRSIZE+1)-1 to 0; `waddr` wraps from 2^ADDRSIZE-1 to 0.
  - The MSB toggle distinguishes full from empty. No false full at the wrap.
- A simultaneous write and `wq2_rptr` advance both take effect in the same `levelnext`.

## Timing
- Every output except `waddr` is a register; `waddr` comes directly from the `wbin` register.
- Latency: one `wclk` edge from `winc` or a `wq2_rptr` change to `wptr`, `waddr`, `wfull`, `walmost_full` and `wlevel`.
- `wfull` rises on the same edge that registers the write filling the last slot.
- `wfull` falls on the first edge after `wq2_rptr` shows a read.
- Reset (asynchronous, immediate, no clock needed): `wbin`, `wptr`, `waddr`, `wlevel` = 0; `wfull`, `walmost_full`, `wovf` = 0.
- Reset mid-operation discards all state. The read side must be reset in the same window.
- `wptr` changes at most one bit per edge, which makes it safe for multi-flop synchronisation.

## Configuration
- Macro: `WPTR_FULL_OVF_EN`.
- Defined:
  - `wovf` sets on the edge after any cycle with `winc & wfull`.
  - It holds until a cycle with `wovf_clr` = 1 and no new overflow; it clears on the following edge.
  - When clear and overflow occur in the same cycle, set wins.
- Undefined:
  - The `wovf_clr` port is absent and `wovf` is tied to 0.
  - No overflow register is built.
  - All other behaviour is identical.

## Test plan
- Fill, with ADDRSIZE=4, `wq2_rptr`=0, `af_thresh`=12, `winc` held for 16 cycles:
  - `waddr` steps 0..15.
  - `walmost_full` rises with `wlevel`=12.
  - `wfull` rises with `wlevel`=16 and `wptr`=5'b11000.
- Overflow (macro defined):
  - Hold `winc` for 3 more cycles while full: `waddr`=0, `wptr`=5'b11000 unchanged, `wovf`=1 after the first dropped write.
  - Pulse `wovf_clr` alone: `wovf`=0 next edge.
  - Pulse `wovf_clr` with a dropped write: `wovf` stays 1.
- Drain while full: set `wq2_rptr`=5'b00110 (binary 4) → next edge `wfull`=0, `wlevel`=12, `walmost_full`=1; then 5'b00111 (binary 5) → `wlevel`=11, `walmost_full`=0.
- Wrap: 40 writes with `wq2_rptr` trailing by 3 →
  - `wptr` goes 5'b10000 (gray 31) → 5'b00000.
  - `waddr` goes 15→0.
  - `wfull` never asserts; `wlevel` holds 3.
- Threshold edges:
  - `af_thresh`=0 → `walmost_full`=1 on the first edge after reset with an empty FIFO.
  - `af_thresh`=17 → `walmost_full` stays 0 even when full.
- Reset mid-operation: drop `wrst_n` between edges with `wlevel`=9 → all outputs 0 immediately; after release the first write gives `waddr`=1, `wlevel`=1.
